// File: rtl/reset_seq_pkg.sv
// Shared encodings for the reset sequencer: FSM states, reset-cause codes
// and the saturating event-counter helper.
package reset_seq_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] cause_t;

    localparam state_t ST_WAIT_LOCK = 2'd0;
    localparam state_t ST_HOLD      = 2'd1;
    localparam state_t ST_RUN       = 2'd2;
    localparam state_t ST_BTN_HELD  = 2'd3;

    localparam cause_t CAUSE_POR       = 2'd0;
    localparam cause_t CAUSE_BUTTON    = 2'd1;
    localparam cause_t CAUSE_LOCK_LOSS = 2'd2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/reset_debounce.sv
// Multi-flop synchronizer followed by a stability filter: dout follows the
// synchronized input only after it has differed for DEBOUNCE_CYCLES edges.
module reset_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic reset_in,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES <= 1) begin : g_bypass
            // A one-cycle filter is the synchronized sample itself; bypassing
            // keeps the path latency at exactly SYNC_STAGES edges.
            assign dout = w_sync;
        end else begin : g_filter
            localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt;
            logic             r_db;

            always_ff @(posedge CLK or posedge reset_in) begin
                if (reset_in) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (w_sync == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_db  <= w_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign dout = r_db;
        end
    endgenerate

endmodule

// File: rtl/reset_sequencer.sv
// System reset sequencer: combines PLL lock, debounced GRESET and a hold-off
// counter into one registered reset, and records the cause of each reset.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 255
) (
    input  logic       CLK,
    input  logic       reset_in,
    input  logic       pll_locked,
    input  logic       button_in,
    output logic       sys_reset,
    output logic [1:0] reset_cause,
    output logic [7:0] reset_events
);

    localparam int unsigned       HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic              w_lock_s;
    logic              w_btn_db;
    state_t            r_state;
    state_t            w_next_state;
    cause_t            r_cause;
    cause_t            w_next_cause;
    logic              w_event;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_sys_reset;
    logic [7:0]        r_events;

    reset_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (1)
    ) u_lock_sync (
        .CLK      (CLK),
        .reset_in (reset_in),
        .din      (pll_locked),
        .dout     (w_lock_s)
    );

    reset_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .CLK      (CLK),
        .reset_in (reset_in),
        .din      (button_in),
        .dout     (w_btn_db)
    );

    // Lock loss outranks the button, which outranks hold-off expiry.
    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_cause;
        w_event      = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cause = CAUSE_LOCK_LOSS;
                end else if (w_btn_db) begin
                    w_next_state = ST_BTN_HELD;
                    w_next_cause = CAUSE_BUTTON;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cause = CAUSE_LOCK_LOSS;
                    w_event      = 1'b1;
                end else if (w_btn_db) begin
                    w_next_state = ST_BTN_HELD;
                    w_next_cause = CAUSE_BUTTON;
                    w_event      = 1'b1;
                end
            end
            ST_BTN_HELD: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cause = CAUSE_LOCK_LOSS;
                end else if (!w_btn_db) begin
                    w_next_state = ST_HOLD;
                end
            end
            default: begin
                w_next_state = ST_WAIT_LOCK;
            end
        endcase
    end

    // hold_cnt restarts from zero on every entry into HOLD because it is
    // held at zero in every other state.
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            r_state     <= ST_WAIT_LOCK;
            r_sys_reset <= 1'b1;
            r_cause     <= CAUSE_POR;
            r_events    <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_sys_reset <= (w_next_state != ST_RUN);
            r_cause     <= w_next_cause;
            if (w_event) begin
                r_events <= sat_inc8(r_events);
            end
            r_hold_cnt  <= (r_state == ST_HOLD) ? r_hold_cnt + 1'b1 : '0;
        end
    end

    assign sys_reset    = r_sys_reset;
    assign reset_cause  = r_cause;
    assign reset_events = r_events;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector table, hand-written corner
// sequences and a random walk, all checked against a countdown-style model.
module tb_reset_sequencer;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 4;

    logic       CLK;
    logic       reset_in;
    logic       pll_locked;
    logic       button_in;
    logic       sys_reset;
    logic [1:0] reset_cause;
    logic [7:0] reset_events;

    int n_checks = 0;
    int n_fail   = 0;

    reset_sequencer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .CLK          (CLK),
        .reset_in     (reset_in),
        .pll_locked   (pll_locked),
        .button_in    (button_in),
        .sys_reset    (sys_reset),
        .reset_cause  (reset_cause),
        .reset_events (reset_events)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: sync pipelines, a "differs for N edges" debouncer,
    // and a reset described by flags plus a hold-off countdown.
    bit m_lk [SYNC];
    bit m_bs [SYNC];
    bit m_db;
    int m_diff;
    bit m_waiting;
    bit m_held;
    int m_remaining;
    int m_cause;
    int m_events;

    function automatic bit m_running();
        return !m_waiting && !m_held && (m_remaining == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(SYNC); i++) begin
            m_lk[i] = 1'b0;
            m_bs[i] = 1'b0;
        end
        m_db        = 1'b0;
        m_diff      = 0;
        m_waiting   = 1'b1;
        m_held      = 1'b0;
        m_remaining = 0;
        m_cause     = 0;
        m_events    = 0;
    endtask

    task automatic model_step();
        bit lock_s;
        bit btn_s;
        bit was_run;
        lock_s  = m_lk[SYNC-1];
        btn_s   = m_bs[SYNC-1];
        was_run = m_running();
        if (m_waiting) begin
            if (lock_s) begin
                m_waiting   = 1'b0;
                m_remaining = HOLD;
            end
        end else if (!lock_s) begin
            m_waiting = 1'b1;
            m_held    = 1'b0;
            m_cause   = 2;
            if (was_run && m_events < 255) m_events++;
        end else if (m_db) begin
            if (!m_held) begin
                m_held  = 1'b1;
                m_cause = 1;
                if (was_run && m_events < 255) m_events++;
            end
        end else if (m_held) begin
            m_held      = 1'b0;
            m_remaining = HOLD;
        end else if (m_remaining > 0) begin
            m_remaining--;
        end
        if (btn_s != m_db) begin
            m_diff++;
            if (m_diff == int'(DEB)) begin
                m_db   = btn_s;
                m_diff = 0;
            end
        end else begin
            m_diff = 0;
        end
        for (int i = int'(SYNC) - 1; i > 0; i--) begin
            m_lk[i] = m_lk[i-1];
            m_bs[i] = m_bs[i-1];
        end
        m_lk[0] = pll_locked;
        m_bs[0] = button_in;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        check("model_sys_reset", 32'(sys_reset), 32'(!m_running()));
        check("model_cause", 32'(reset_cause), 32'(m_cause));
        check("model_events", 32'(reset_events), 32'(m_events));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset();
        #2 reset_in = 1'b1;
        #1;
        check("async_sys_reset", 32'(sys_reset), 32'd1);
        check("async_cause", 32'(reset_cause), 32'd0);
        check("async_events", 32'(reset_events), 32'd0);
        model_reset();
        #1 reset_in = 1'b0;
    endtask

    typedef struct {
        bit          pll;
        bit          btn;
        int          cycles;
        bit          exp_sys;
        logic [1:0]  exp_cause;
        logic [7:0]  exp_events;
    } vec_t;

    vec_t tbl [9];

    initial begin
        // POR release, then a full button press/release cycle.
        tbl[0] = '{pll: 1'b0, btn: 1'b0, cycles: 2,  exp_sys: 1'b1, exp_cause: 2'd0, exp_events: 8'd0};
        tbl[1] = '{pll: 1'b1, btn: 1'b0, cycles: 6,  exp_sys: 1'b1, exp_cause: 2'd0, exp_events: 8'd0};
        tbl[2] = '{pll: 1'b1, btn: 1'b0, cycles: 1,  exp_sys: 1'b0, exp_cause: 2'd0, exp_events: 8'd0};
        tbl[3] = '{pll: 1'b1, btn: 1'b0, cycles: 5,  exp_sys: 1'b0, exp_cause: 2'd0, exp_events: 8'd0};
        tbl[4] = '{pll: 1'b1, btn: 1'b1, cycles: 6,  exp_sys: 1'b0, exp_cause: 2'd0, exp_events: 8'd0};
        tbl[5] = '{pll: 1'b1, btn: 1'b1, cycles: 1,  exp_sys: 1'b1, exp_cause: 2'd1, exp_events: 8'd1};
        tbl[6] = '{pll: 1'b1, btn: 1'b1, cycles: 3,  exp_sys: 1'b1, exp_cause: 2'd1, exp_events: 8'd1};
        tbl[7] = '{pll: 1'b1, btn: 1'b0, cycles: 10, exp_sys: 1'b1, exp_cause: 2'd1, exp_events: 8'd1};
        tbl[8] = '{pll: 1'b1, btn: 1'b0, cycles: 1,  exp_sys: 1'b0, exp_cause: 2'd1, exp_events: 8'd1};

        reset_in   = 1'b1;
        pll_locked = 1'b0;
        button_in  = 1'b0;
        model_reset();
        #1;
        check("por_sys_reset", 32'(sys_reset), 32'd1);
        check("por_cause", 32'(reset_cause), 32'd0);
        check("por_events", 32'(reset_events), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        reset_in = 1'b0;

        for (int v = 0; v < 9; v++) begin
            pll_locked = tbl[v].pll;
            button_in  = tbl[v].btn;
            steps(tbl[v].cycles);
            check($sformatf("vec%0d_sys_reset", v), 32'(sys_reset), 32'(tbl[v].exp_sys));
            check($sformatf("vec%0d_cause", v), 32'(reset_cause), 32'(tbl[v].exp_cause));
            check($sformatf("vec%0d_events", v), 32'(reset_events), 32'(tbl[v].exp_events));
        end

        // Bounce shorter than the debounce window must never reset.
        for (int i = 0; i < 20; i++) begin
            button_in = ((i / 2) % 2 == 0);
            step();
            check("bounce_sys_reset", 32'(sys_reset), 32'd0);
        end
        button_in = 1'b0;
        steps(6);
        check("bounce_events", 32'(reset_events), 32'd1);

        // Lock loss during HOLD with the button pressed, on the edge the
        // hold-off would otherwise expire.
        button_in = 1'b1;
        steps(7);
        check("ll_btn_entry", 32'(reset_events), 32'd2);
        button_in = 1'b0;
        steps(8);
        button_in  = 1'b1;
        pll_locked = 1'b0;
        steps(3);
        check("ll_sys_reset", 32'(sys_reset), 32'd1);
        check("ll_cause", 32'(reset_cause), 32'd2);
        check("ll_events", 32'(reset_events), 32'd2);
        button_in = 1'b0;
        steps(8);
        pll_locked = 1'b1;
        steps(6);
        check("relock_held", 32'(sys_reset), 32'd1);
        steps(1);
        check("relock_release", 32'(sys_reset), 32'd0);
        check("relock_cause", 32'(reset_cause), 32'd2);

        // Saturation of the event counter.
        for (int k = 0; k < 300; k++) begin
            button_in = 1'b1;
            steps(7);
            button_in = 1'b0;
            steps(11);
        end
        check("sat_events", 32'(reset_events), 32'd255);
        check("sat_sys_reset", 32'(sys_reset), 32'd0);
        button_in = 1'b1;
        steps(8);
        check("sat_hold", 32'(reset_events), 32'd255);

        // Asynchronous reset while in BTN_HELD.
        check("pre_async_sys_reset", 32'(sys_reset), 32'd1);
        pulse_reset();
        pll_locked = 1'b0;
        button_in  = 1'b0;
        steps(3);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) pll_locked = ~pll_locked;
            if ($urandom_range(0, 7) == 0) button_in = ~button_in;
            if ($urandom_range(0, 799) == 0) pulse_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
